// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
//   adder_state_e : FSM state encoding (idle / run / result-valid)
//   clog2()       : ceiling log2, used to size the beat counter
package adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } adder_state_e;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell.
//   x, y  : addend bits
//   c_in  : carry in
//   sum   : x ^ y ^ c_in
//   c_out : carry out
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: sum = a + b + c_in (mod 2**WIDTH), DIGIT bits per clock through a ripple
// chain of DIGIT full-adder cells. The carry is held in a register between beats.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request an addition (ignored while busy)
//   a, b, c_in     : operands, captured on the accepting edge
//   busy           : addition in progress
//   done           : one-cycle result-valid pulse
//   sum            : result shift register (only meaningful while busy is low)
//   c_out          : carry out of the MSB
//   overflow       : two's-complement overflow
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH evenly");
    end

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (clog2(N + 1) > 1) ? clog2(N + 1) : 1;

    adder_state_e     state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_out_q, ovf_q;

    logic             accept, step, last;
    logic [DIGIT-1:0] digit_sum;
    logic [DIGIT:0]   carry;
    logic [WIDTH-1:0] sum_shift;

    // Ripple chain over the low DIGIT bits of the operand shift registers.
    assign carry[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder u_fa (
            .x     (a_q[i]),
            .y     (b_q[i]),
            .c_in  (carry[i]),
            .sum   (digit_sum[i]),
            .c_out (carry[i+1])
        );
    end

    // New digit enters at the MSB end; after N beats the first digit has reached the LSB.
    if (WIDTH > DIGIT) begin : g_shift
        assign sum_shift = {digit_sum, sum_q[WIDTH-1:DIGIT]};
    end else begin : g_single
        assign sum_shift = digit_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    last    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            sum_q   <= sum_shift;
            carry_q <= carry[DIGIT];
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last) begin
                // On the final beat the last cell is the MSB cell.
                c_out_q <= carry[DIGIT];
                ovf_q   <= carry[DIGIT-1] ^ carry[DIGIT];
            end
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit instances with DIGIT 1 and 4, plus 4-bit instances with
// DIGIT 1, 2 and 4 swept over every operand combination.
module tb_serial_adder;

    localparam int BUDGET = 40;

    logic clk;
    logic rst_n;

    logic       start8[2];
    logic [7:0] a8[2], b8[2];
    logic       c8[2];
    logic       busy8[2], done8[2], cout8[2], ovf8[2];
    logic [7:0] sum8[2];

    logic       start4[3];
    logic [3:0] a4[3], b4[3];
    logic       c4[3];
    logic       busy4[3], done4[3], cout4[3], ovf4[3];
    logic [3:0] sum4[3];

    int n_checks;
    int n_fail;

    for (genvar g = 0; g < 2; g++) begin : g_dut8
        serial_adder #(.WIDTH(8), .DIGIT(g == 0 ? 1 : 4)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start8[g]),
            .a        (a8[g]),
            .b        (b8[g]),
            .c_in     (c8[g]),
            .busy     (busy8[g]),
            .done     (done8[g]),
            .sum      (sum8[g]),
            .c_out    (cout8[g]),
            .overflow (ovf8[g])
        );
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut4
        serial_adder #(.WIDTH(4), .DIGIT(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start4[g]),
            .a        (a4[g]),
            .b        (b4[g]),
            .c_in     (c4[g]),
            .busy     (busy4[g]),
            .done     (done4[g]),
            .sum      (sum4[g]),
            .c_out    (cout4[g]),
            .overflow (ovf4[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one 8-bit operation from the current negedge and check it at its done cycle.
    task automatic op8(input int i, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [7:0] es, input logic ec, input logic eo, input int el,
                       input string nm);
        int lat;
        int bc;
        start8[i] = 1'b1;
        a8[i]     = av;
        b8[i]     = bv;
        c8[i]     = cv;
        @(negedge clk);
        start8[i] = 1'b0;
        a8[i]     = ~av;
        b8[i]     = ~bv;
        c8[i]     = ~cv;
        lat = 0;
        bc  = (busy8[i] === 1'b1) ? 1 : 0;
        while (done8[i] !== 1'b1 && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (busy8[i] === 1'b1) bc++;
        end
        n_checks++;
        if (lat !== el) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, el);
        end
        n_checks++;
        if (bc !== el) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d want %0d", nm, bc, el);
        end
        n_checks++;
        if (sum8[i] !== es) begin
            n_fail++;
            $display("FAIL %s sum: got %h want %h", nm, sum8[i], es);
        end
        n_checks++;
        if (cout8[i] !== ec) begin
            n_fail++;
            $display("FAIL %s c_out: got %b want %b", nm, cout8[i], ec);
        end
        n_checks++;
        if (ovf8[i] !== eo) begin
            n_fail++;
            $display("FAIL %s overflow: got %b want %b", nm, ovf8[i], eo);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({busy8[i], done8[i], sum8[i], cout8[i], ovf8[i]} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset dut8[%0d]: got busy=%b done=%b sum=%h c_out=%b ovf=%b want 0",
                         i, busy8[i], done8[i], sum8[i], cout8[i], ovf8[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_carry;
        op8(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, "ff+01");
        @(negedge clk);
        n_checks++;
        if (done8[0] !== 1'b0 || sum8[0] !== 8'h00 || cout8[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ff+01 hold: got done=%b sum=%h c_out=%b want 0 00 1",
                     done8[0], sum8[0], cout8[0]);
        end
    endtask

    task automatic test_overflow;
        op8(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8, "7f+01");
        @(negedge clk);
        op8(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 8, "80+80");
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        op8(1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 2, "a5+5a+1");
        op8(1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 2, "12+34 b2b");
        @(negedge clk);
        n_checks++;
        if (done8[1] !== 1'b0 || busy8[1] !== 1'b0 || sum8[1] !== 8'h46) begin
            n_fail++;
            $display("FAIL b2b idle hold: got done=%b busy=%b sum=%h want 0 0 46",
                     done8[1], busy8[1], sum8[1]);
        end
    endtask

    task automatic test_ignored_start;
        int ndone;
        int first;
        logic [7:0] s;
        logic co, ov;
        ndone = 0;
        first = 0;
        s = 8'h00;
        co = 1'b0;
        ov = 1'b0;
        start8[0] = 1'b1;
        a8[0] = 8'h10;
        b8[0] = 8'h20;
        c8[0] = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            start8[0] = (k == 3);
            a8[0] = 8'hFF;
            b8[0] = 8'hFF;
            c8[0] = 1'b1;
            @(negedge clk);
            if (done8[0] === 1'b1) begin
                ndone++;
                if (first == 0) begin
                    first = k;
                    s = sum8[0];
                    co = cout8[0];
                    ov = ovf8[0];
                end
            end
        end
        start8[0] = 1'b0;
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL ignored start done count: got %0d want 1", ndone);
        end
        n_checks++;
        if (first !== 8) begin
            n_fail++;
            $display("FAIL ignored start latency: got %0d want 8", first);
        end
        n_checks++;
        if ({co, ov, s} !== {1'b0, 1'b0, 8'h30}) begin
            n_fail++;
            $display("FAIL ignored start result: got c_out=%b ovf=%b sum=%h want 0 0 30",
                     co, ov, s);
        end
    endtask

    task automatic test_midrun_reset;
        int ndone;
        start8[0] = 1'b1;
        a8[0] = 8'h55;
        b8[0] = 8'h0F;
        c8[0] = 1'b0;
        @(negedge clk);
        start8[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy8[0] !== 1'b1 || sum8[0] === 8'h00) begin
            n_fail++;
            $display("FAIL pre-reset run: got busy=%b sum=%h want busy=1 sum nonzero",
                     busy8[0], sum8[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8[0], done8[0], sum8[0], cout8[0], ovf8[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL midrun reset: got busy=%b done=%b sum=%h c_out=%b ovf=%b want 0",
                     busy8[0], done8[0], sum8[0], cout8[0], ovf8[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8[0] === 1'b1 || busy8[0] === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL post-reset activity: got %0d busy/done cycles want 0", ndone);
        end
        op8(0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 8, "03+04 after reset");
        @(negedge clk);
    endtask

    // Exhaustive 4-bit sweep; consecutive operations run back to back.
    task automatic test_sweep4;
        int lat;
        logic [4:0] tot;
        logic eo;
        for (int k = 0; k < 3; k++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    for (int c = 0; c < 2; c++) begin
                        tot = 5'(x) + 5'(y) + 5'(c);
                        eo  = (x[3] == y[3]) && (tot[3] != x[3]);
                        start4[k] = 1'b1;
                        a4[k] = 4'(x);
                        b4[k] = 4'(y);
                        c4[k] = c[0];
                        @(negedge clk);
                        start4[k] = 1'b0;
                        a4[k] = 4'(~x);
                        b4[k] = 4'(~y);
                        c4[k] = ~c[0];
                        lat = 0;
                        while (done4[k] !== 1'b1 && lat < BUDGET) begin
                            @(negedge clk);
                            lat++;
                        end
                        n_checks++;
                        if (lat !== (4 >> k)) begin
                            n_fail++;
                            $display("FAIL sweep d%0d %h+%h+%0d latency: got %0d want %0d",
                                     1 << k, x[3:0], y[3:0], c, lat, 4 >> k);
                        end
                        n_checks++;
                        if ({cout4[k], sum4[k]} !== tot) begin
                            n_fail++;
                            $display("FAIL sweep d%0d %h+%h+%0d sum: got %h want %h",
                                     1 << k, x[3:0], y[3:0], c, {cout4[k], sum4[k]}, tot);
                        end
                        n_checks++;
                        if (ovf4[k] !== eo) begin
                            n_fail++;
                            $display("FAIL sweep d%0d %h+%h+%0d overflow: got %b want %b",
                                     1 << k, x[3:0], y[3:0], c, ovf4[k], eo);
                        end
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start8[i] = 1'b0;
            a8[i] = 8'h00;
            b8[i] = 8'h00;
            c8[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            start4[i] = 1'b0;
            a4[i] = 4'h0;
            b4[i] = 4'h0;
            c4[i] = 1'b0;
        end
        #2;
        test_reset();
        test_carry();
        test_overflow();
        test_back_to_back();
        test_ignored_start();
        test_midrun_reset();
        test_sweep4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
